jericalla_secuenciador: RTL
===========================

Name: jericalla_secuenciador

Overview:
- Program sequencer for the Jericalla datapath (ROM/RAM/ALU driven by a 17-bit `instruccion`, producing 32-bit `salida` and zero flag `ZF_J`).
- Fetches 20-bit program words from a synchronous program memory and presents each 17-bit instruction to the datapath.
- Holds each instruction for a fixed settle time, then captures the result and flag.
- Supports conditional/unconditional jumps and halt, so the datapath runs whole programs instead of bench-driven single instructions.

Parameters:
- ANCHO_PC, 8, program counter / program memory address width.
- LAT_DP, 2, cycles `instruccion` is held before `salida`/`ZF_J` are sampled (legal range 1..15).
- ANCHO_CNT, 16, width of executed-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin program at address 0; sampled only in IDLE.
- pc_addr  out  ANCHO_PC  program memory read address.
- prog_dato  in  20  program word; valid the cycle after pc_addr is driven (synchronous read).
- instruccion  out  17  instruction to datapath.
- salida_dp  in  32  datapath result (Jericalla `salida`).
- zf_dp  in  1  datapath zero flag (Jericalla `ZF_J`).
- resultado  out  32  last captured result.
- zf_reg  out  1  last captured zero flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when HALT is executed.
- cuenta_instr  out  ANCHO_CNT  EXEC instructions completed since last start.

Behaviour:
- Reset values: all outputs 0; state IDLE; pc 0; settle counter 0. Reset is asynchronous and takes effect at any state, including mid-EXEC. `instruccion` returns to 0 immediately.
- Program word format:
  - [19:17] op: 000 EXEC, 001 BZ, 010 JMP, 111 HALT; 011–110 are NOP.
  - [16:0] payload: the instruction for EXEC; the target pc[ANCHO_PC-1:0] for BZ/JMP.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - On start=1: pc<=0, cuenta_instr<=0, next state FETCH.
  - Otherwise stay. start is ignored in every other state.
- FETCH: pc_addr=pc. Next state DECODE.
- DECODE: prog_dato is valid and registered into the op/payload registers.
  - EXEC: instruccion<=payload, settle counter<=0, next state EXEC.
  - BZ: if zf_reg=1 then pc<=target, else pc<=pc+1. Next state FETCH.
  - JMP: pc<=target, next state FETCH.
  - HALT: pc unchanged, next state DONE.
  - NOP: pc<=pc+1, next state FETCH.
- EXEC:
  - instruccion is held stable; the counter increments each cycle.
  - In the cycle where counter==LAT_DP-1: resultado<=salida_dp, zf_reg<=zf_dp, pc<=pc+1, cuenta_instr<=cuenta_instr+1 (saturating at all-ones), next state FETCH.
  - Latency: one EXEC word costs 2+LAT_DP cycles, BZ/JMP/NOP cost 2, HALT costs 3 (including DONE).
- DONE: done=1 for exactly one cycle, next state IDLE. resultado, zf_reg, cuenta_instr and pc hold until the next start.
- instruccion holds its last issued value outside EXEC; it changes only on DECODE of an EXEC word or on reset.
- pc increment wraps from 2^ANCHO_PC-1 to 0; jump targets are truncated to ANCHO_PC bits.
- BZ uses the flag captured by the most recent EXEC. After start with no EXEC yet, zf_reg keeps its prior value (0 after reset).
- A new start in IDLE does not clear resultado or zf_reg.

Test Plan (LAT_DP=2, datapath modelled by the Jericalla instance preloaded with its ROM/RAM files):
- Reset mid-EXEC: assert rst while executing instruction 17'b00001111111111110 -> same cycle all outputs 0, state IDLE; deassert and pulse start -> first pc_addr=0 one cycle later.
- Single EXEC then HALT (words 0: {000,17'b0}, 1: {111,0}):
  - start at cycle t -> instruccion=0 from t+3.
  - resultado captured at end of t+4; done pulses at cycle t+8; cuenta_instr=1.
- BZ taken vs not taken:
  - Program EXEC producing salida=0, BZ to 5, HALT at 2, HALT at 5 -> halts with pc=5.
  - Same program with a nonzero result -> halts with pc=2.
- JMP loop with counter saturation: ANCHO_CNT=4, program {EXEC; JMP 0} runs 20 iterations -> cuenta_instr sticks at 15; busy stays 1.
- PC wrap: ANCHO_PC=3, NOPs at 0–7 and HALT at 0 only on the second pass (reload memory) -> pc_addr sequence 0..7,0; no X states.
- start ignored when busy: pulse start during EXEC -> pc and cuenta_instr unaffected; second start after done restarts at pc_addr=0 with cuenta_instr=0.

Source files
------------

// File: rtl/jericalla_secuenciador.sv
// -----------------------------------------------------------------------------
// jericalla_secuenciador
//
// Program sequencer for the Jericalla datapath. Fetches 20-bit program words
// from a synchronous-read program memory, issues the 17-bit instruction of
// each EXEC word to the datapath, waits LAT_DP cycles for the datapath to
// settle, then captures its result and zero flag. BZ/JMP/HALT/NOP words give
// flow control so whole programs run without external sequencing.
//
// Program word: [19:17] op (000 EXEC, 001 BZ, 010 JMP, 111 HALT, others NOP)
//               [16:0]  payload (instruction for EXEC, target pc for BZ/JMP)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        launch program at address 0 (only looked at in IDLE)
//   pc_addr      program memory read address
//   prog_dato    program word, valid the cycle after pc_addr
//   instruccion  instruction presented to the datapath
//   salida_dp    datapath result
//   zf_dp        datapath zero flag
//   resultado    last captured datapath result
//   zf_reg       last captured datapath zero flag
//   busy         high whenever the sequencer is not IDLE
//   done         one-cycle pulse after a HALT has been executed
//   cuenta_instr saturating count of EXEC words completed since start
// -----------------------------------------------------------------------------
module jericalla_secuenciador #(
  parameter int ANCHO_PC  = 8,   // must not exceed 17 (target lives in payload)
  parameter int LAT_DP    = 2,   // 1..15
  parameter int ANCHO_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ANCHO_PC-1:0]  pc_addr,
  input  logic [19:0]          prog_dato,
  output logic [16:0]          instruccion,
  input  logic [31:0]          salida_dp,
  input  logic                 zf_dp,
  output logic [31:0]          resultado,
  output logic                 zf_reg,
  output logic                 busy,
  output logic                 done,
  output logic [ANCHO_CNT-1:0] cuenta_instr
);

  localparam logic [2:0] OP_EXEC = 3'b000;
  localparam logic [2:0] OP_BZ   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [3:0]           SETTLE_LAST = 4'(LAT_DP - 1);
  localparam logic [ANCHO_PC-1:0]  PC_UNO      = 1;
  localparam logic [ANCHO_CNT-1:0] CNT_UNO     = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [ANCHO_PC-1:0]  pc_q, pc_d;
  logic [3:0]           settle_q, settle_d;
  logic [16:0]          instr_q, instr_d;
  logic [31:0]          res_q, res_d;
  logic                 zf_q, zf_d;
  logic                 done_q, done_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

  // Program word fields, only meaningful while in DECODE.
  logic [2:0]          op;
  logic [16:0]         payload;
  logic [ANCHO_PC-1:0] target;
  logic [ANCHO_PC-1:0] pc_inc;

  assign op      = prog_dato[19:17];
  assign payload = prog_dato[16:0];
  assign target  = prog_dato[ANCHO_PC-1:0];
  assign pc_inc  = pc_q + PC_UNO;   // natural wrap at 2^ANCHO_PC

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    settle_d = settle_q;
    instr_d  = instr_q;
    res_d    = res_q;
    zf_d     = zf_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (estado_q)
      S_IDLE: begin
        // resultado/zf_reg deliberately survive a new start so BZ can
        // still see the flag left by the previous run.
        if (start) begin
          pc_d     = '0;
          cnt_d    = '0;
          estado_d = S_FETCH;
        end
      end

      S_FETCH: estado_d = S_DECODE;

      S_DECODE: begin
        case (op)
          OP_EXEC: begin
            instr_d  = payload;
            settle_d = '0;
            estado_d = S_EXEC;
          end
          OP_BZ: begin
            pc_d     = zf_q ? target : pc_inc;
            estado_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d     = target;
            estado_d = S_FETCH;
          end
          OP_HALT: estado_d = S_DONE;
          default: begin
            pc_d     = pc_inc;
            estado_d = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          res_d    = salida_dp;
          zf_d     = zf_dp;
          pc_d     = pc_inc;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_UNO;
          estado_d = S_FETCH;
        end
      end

      // done is registered, so it pulses in the cycle after DONE.
      S_DONE: begin
        done_d   = 1'b1;
        estado_d = S_IDLE;
      end

      default: estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= S_IDLE;
      pc_q     <= '0;
      settle_q <= '0;
      instr_q  <= '0;
      res_q    <= '0;
      zf_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      settle_q <= settle_d;
      instr_q  <= instr_d;
      res_q    <= res_d;
      zf_q     <= zf_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_addr      = pc_q;
  assign instruccion  = instr_q;
  assign resultado    = res_q;
  assign zf_reg       = zf_q;
  assign done         = done_q;
  assign cuenta_instr = cnt_q;
  assign busy         = (estado_q != S_IDLE);

endmodule
